// File: rtl/serial_in_loader_4b.sv
// Serial-to-parallel front end for the 4-bit load register: collects an LSB-first word under a
// start/valid handshake, then presents it on data with a one-cycle ld pulse. Optional: PARITY_CHK_EN.
module serial_in_loader_4b (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sin,
  input  logic       sin_valid,
  output logic [3:0] data,
  output logic       ld,
  output logic       busy,
  output logic       err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // With parity the frame carries a fifth bit, so the last capture happens one count later.
`ifdef PARITY_CHK_EN
  localparam logic [2:0] LAST_CNT = 3'd4;
`else
  localparam logic [2:0] LAST_CNT = 3'd3;
`endif

  state_t     state, state_nxt;
  logic [3:0] sreg, sreg_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [3:0] data_q, data_nxt;
  logic       ld_q, ld_nxt;
  logic [3:0] shifted;
  logic       last_bit;

`ifdef PARITY_CHK_EN
  logic       err_q, err_nxt;
`endif

  assign shifted  = {sin, sreg[3:1]};
  assign last_bit = (cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments only; the combinational block below
  // computes every next value with blocking assignments, so the two never race.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= 4'b0000;
      cnt    <= 3'd0;
      data_q <= 4'b0000;
      ld_q   <= 1'b0;
`ifdef PARITY_CHK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      ld_q   <= ld_nxt;
`ifdef PARITY_CHK_EN
      err_q  <= err_nxt;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred. ld/err default low, which makes them single-cycle pulses.
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    ld_nxt    = 1'b0;
`ifdef PARITY_CHK_EN
    err_nxt   = 1'b0;
`endif

    case (state)
      IDLE: begin
        // sin_valid is deliberately not looked at here.
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = 3'd0;
          sreg_nxt  = 4'b0000;
        end
      end

      SHIFT: begin
        // start is ignored: a running frame cannot be restarted, only aborted by rst.
        if (sin_valid) begin
          cnt_nxt = cnt + 3'd1;
          if (last_bit) begin
            state_nxt = IDLE;
`ifdef PARITY_CHK_EN
            // sreg already holds the four data bits; sin is the even-parity bit.
            if ((^sreg) ^ sin) begin
              err_nxt = 1'b1;
            end else begin
              data_nxt = sreg;
              ld_nxt   = 1'b1;
            end
`else
            sreg_nxt = shifted;
            data_nxt = shifted;
            ld_nxt   = 1'b1;
`endif
          end else begin
            sreg_nxt = shifted;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign data = data_q;
  assign ld   = ld_q;
  assign busy = (state == SHIFT);

`ifdef PARITY_CHK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // A completion always returns to IDLE, so two back-to-back pulses are impossible.
  a_ld_single : assert property (@(posedge clk) disable iff (rst) ld |=> !ld);
  a_ld_err_excl : assert property (@(posedge clk) !(ld && err));

endmodule

// File: tb/tb_serial_in_loader_4b.sv
// Directed self-checking bench for serial_in_loader_4b; parity vectors run when PARITY_CHK_EN is defined.
module tb_serial_in_loader_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sin;
  logic       sin_valid;
  logic [3:0] data;
  logic       ld;
  logic       busy;
  logic       err;

`ifdef PARITY_CHK_EN
  localparam int FRAME = 6;
`else
  localparam int FRAME = 5;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ld_count = 0;
  int ld_twice = 0;
  int ld_and_err = 0;
  logic ld_prev = 1'b0;
  logic [3:0] q;   // downstream load register

  serial_in_loader_4b dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .data      (data),
    .ld        (ld),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)     q <= 4'b0000;
    else if (ld) q <= data;
  end

  always @(negedge clk) begin
    if (ld) ld_count++;
    if (ld && ld_prev) ld_twice++;
    if (ld && err) ld_and_err++;
    ld_prev = ld;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic v);
    start     = s;
    sin       = b;
    sin_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    step(1'b0, b, 1'b1);
  endtask

  // Appends the even-parity bit when frames carry one.
  task automatic send_par(input logic [3:0] w);
`ifdef PARITY_CHK_EN
    send_bit(^w);
`else
    if (w === 4'bxxxx) send_bit(1'b0);
`endif
  endtask

  int t_ld1;
  int n0;

  initial begin
    rst = 1'b0; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;

    // Reset overrides start/sin_valid.
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check("rst_data", data, 4'b0000);
    check("rst_ld",   ld,   1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err",  err,  1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_hold_busy", busy, 1'b0);

    // Basic frame 0101 (bits 1,0,1,0 LSB first).
    step(1'b1, 1'b0, 1'b0);
    check("basic_busy_start", busy, 1'b1);
    send_bit(1'b1);
    check("basic_busy_b1", busy, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("basic_ld_early", ld, 1'b0);
    send_bit(1'b0);
    send_par(4'b0101);
    check("basic_data", data, 4'b0101);
    check("basic_ld",   ld,   1'b1);
    check("basic_busy_end", busy, 1'b0);
    check("basic_err",  err,  1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("basic_ld_clear",  ld,   1'b0);
    check("basic_data_hold", data, 4'b0101);
    check("basic_q",         q,    4'b0101);

    // Gapped frame 1110 (bits 0,1,1,1) with a start pulse inside the gap.
    n0 = ld_count;
    step(1'b1, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("gap_busy", busy, 1'b1);
    check("gap_ld",   ld,   1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_par(4'b1110);
    check("gap_data", data, 4'b1110);
    check("gap_ld_end", ld, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("gap_ld_pulses", ld_count - n0, 1);

    // sin_valid in IDLE changes nothing.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("idle_valid_busy", busy, 1'b0);
    check("idle_valid_ld",   ld,   1'b0);
    check("idle_valid_data", data, 4'b1110);

    // Back-to-back: 1010 (bits 0,1,0,1), start in the ld cycle, then 1011 (bits 1,1,0,1).
    step(1'b1, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_par(4'b1010);
    check("b2b_data1", data, 4'b1010);
    check("b2b_ld1",   ld,   1'b1);
    t_ld1 = cyc;
    step(1'b1, 1'b0, 1'b0);
    check("b2b_busy", busy, 1'b1);
    check("b2b_q1",   q,    4'b1010);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_par(4'b1011);
    check("b2b_data2", data, 4'b1011);
    check("b2b_ld2",   ld,   1'b1);
    check("b2b_spacing", cyc - t_ld1, FRAME);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_q2", q, 4'b1011);

    // Abort after two bits, then frame 0011 (bits 1,1,0,0).
    n0 = ld_count;
    step(1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ld",   ld,   1'b0);
    check("abort_data", data, 4'b0000);
    step(1'b0, 1'b0, 1'b0);
    check("abort_no_pulse", ld_count - n0, 0);
    step(1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_par(4'b0011);
    check("after_abort_data", data, 4'b0011);
    check("after_abort_ld",   ld,   1'b1);
    step(1'b0, 1'b0, 1'b0);

`ifdef PARITY_CHK_EN
    // Good parity: 0101 + 0.
    step(1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("par_ok_ld_early", ld, 1'b0);
    send_bit(1'b0);
    check("par_ok_ld",   ld,   1'b1);
    check("par_ok_data", data, 4'b0101);
    check("par_ok_err",  err,  1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Bad parity: 0111 + 0.
    step(1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("par_bad_err",  err,  1'b1);
    check("par_bad_ld",   ld,   1'b0);
    check("par_bad_data", data, 4'b0101);
    check("par_bad_busy", busy, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("par_bad_err_clear", err, 1'b0);
`else
    check("err_tied", err, 1'b0);
`endif

    step(1'b0, 1'b0, 1'b0);
    check("ld_never_twice", ld_twice, 0);
    check("ld_err_exclusive", ld_and_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
